// File: rtl/satswarmv2_pkg.sv
// ============================================================================
// Module      : satswarmv2_pkg
// Description : Shared NoC packet types, message codes and link defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package satswarmv2_pkg;

    typedef enum logic [2:0] {
        MSG_NOP     = 3'd0,
        MSG_DIVERGE = 3'd1,
        MSG_CLAUSE  = 3'd2,
        MSG_STATUS  = 3'd3,
        MSG_SHARE   = 3'd4
    } msg_type_e;

    typedef struct packed {
        msg_type_e   msg_type;
        logic [7:0]  src_id;
        logic [7:0]  quality_metric;
        logic [63:0] payload;
    } noc_packet_t;

    localparam int         NOC_DIV_DEPTH       = 2;
    localparam int         NOC_CLS_DEPTH       = 4;
    localparam logic [7:0] NOC_LBD_MAX_DEFAULT = 8'd6;

    // Low-quality clauses (high LBD) are not worth forwarding across the mesh.
    function automatic logic is_lbd_filtered(input noc_packet_t pkt, input logic [7:0] lbd_max);
        return (pkt.msg_type == MSG_CLAUSE) && (pkt.quality_metric > lbd_max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_pkt_fifo.sv
// ============================================================================
// Module      : noc_pkt_fifo
// Description : Registered circular packet queue with occupancy and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_pkt_fifo
    import satswarmv2_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  noc_packet_t                  push_pkt,
    input  logic                         pop,
    output noc_packet_t                  head_pkt,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam int                 CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    noc_packet_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_pkt  = r_mem[r_rd_ptr];

    // Flush wins over any same-cycle push or pop.
    assign w_do_push = push && !full  && !flush;
    assign w_do_pop  = pop  && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_pkt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_link_channel.sv
// ============================================================================
// Module      : noc_link_channel
// Description : Two-class buffered NoC link; divergence strictly ahead of
//               clause traffic, with LBD filtering of clauses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_link_channel
    import satswarmv2_pkg::*;
#(
    parameter int         DIV_DEPTH = NOC_DIV_DEPTH,
    parameter int         CLS_DEPTH = NOC_CLS_DEPTH,
    parameter logic [7:0] LBD_MAX   = NOC_LBD_MAX_DEFAULT
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  noc_packet_t                       in_pkt,
    input  logic                              in_valid,
    output logic                              in_ready,
    output noc_packet_t                       out_pkt,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              flush,
    output logic [$clog2(DIV_DEPTH+1)-1:0]    div_count,
    output logic [$clog2(CLS_DEPTH+1)-1:0]    cls_count,
    output logic [15:0]                       drop_cnt
);

    logic          w_is_div;
    logic          w_is_drop;
    logic          w_accept;
    logic          w_div_push;
    logic          w_cls_push;
    logic          w_div_pop;
    logic          w_cls_pop;
    logic          w_div_full;
    logic          w_div_empty;
    logic          w_cls_full;
    logic          w_cls_empty;
    noc_packet_t   w_div_head;
    noc_packet_t   w_cls_head;
    logic [15:0]   r_drop_cnt;

    assign w_is_div  = (in_pkt.msg_type == MSG_DIVERGE);
    assign w_is_drop = is_lbd_filtered(in_pkt, LBD_MAX);

    // Independent of in_valid/out_ready so the sender's ack logic sees no loop.
    assign in_ready  = !flush && (w_is_div  ? !w_div_full :
                                  w_is_drop ? 1'b1        : !w_cls_full);

    assign w_accept   = in_valid && in_ready;
    assign w_div_push = w_accept && w_is_div;
    assign w_cls_push = w_accept && !w_is_div && !w_is_drop;

    assign out_valid  = !w_div_empty || !w_cls_empty;
    assign w_div_pop  = out_ready && !w_div_empty;
    assign w_cls_pop  = out_ready &&  w_div_empty && !w_cls_empty;

    always_comb begin
        out_pkt = '0;
        if (!w_div_empty) begin
            out_pkt = w_div_head;
        end else if (!w_cls_empty) begin
            out_pkt = w_cls_head;
        end
    end

    noc_pkt_fifo #(
        .DEPTH    (DIV_DEPTH)
    ) u_div_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (w_div_push),
        .push_pkt (in_pkt),
        .pop      (w_div_pop),
        .head_pkt (w_div_head),
        .full     (w_div_full),
        .empty    (w_div_empty),
        .count    (div_count)
    );

    noc_pkt_fifo #(
        .DEPTH    (CLS_DEPTH)
    ) u_cls_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (w_cls_push),
        .push_pkt (in_pkt),
        .pop      (w_cls_pop),
        .head_pkt (w_cls_head),
        .full     (w_cls_full),
        .empty    (w_cls_empty),
        .count    (cls_count)
    );

    // Drop count survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_is_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_noc_link_channel.sv
// ============================================================================
// Module      : tb_noc_link_channel
// Description : Self-checking bench for noc_link_channel with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_link_channel;
    import satswarmv2_pkg::*;

    localparam int         DIV = 2;
    localparam int         CLS = 4;
    localparam logic [7:0] LBD = 8'd6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    noc_packet_t   in_pkt;
    logic          in_valid;
    logic          in_ready;
    noc_packet_t   out_pkt;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [1:0]    div_count;
    logic [2:0]    cls_count;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    noc_link_channel #(
        .DIV_DEPTH (DIV),
        .CLS_DEPTH (CLS),
        .LBD_MAX   (LBD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .div_count (div_count),
        .cls_count (cls_count),
        .drop_cnt  (drop_cnt)
    );

    int          total = 0;
    int          bad   = 0;
    noc_packet_t div_q[$];
    noc_packet_t cls_q[$];
    int          drops = 0;

    function automatic noc_packet_t mk(input msg_type_e t, input logic [7:0] q, input logic [63:0] pl);
        noc_packet_t p;
        p.msg_type       = t;
        p.src_id         = pl[7:0] ^ 8'h5A;
        p.quality_metric = q;
        p.payload        = pl;
        return p;
    endfunction

    function automatic logic model_ready(input noc_packet_t p, input logic fl);
        if (fl) return 1'b0;
        if (p.msg_type == MSG_DIVERGE) return div_q.size() < DIV;
        if (p.msg_type == MSG_CLAUSE && p.quality_metric > LBD) return 1'b1;
        return cls_q.size() < CLS;
    endfunction

    function automatic noc_packet_t model_head();
        if (div_q.size() > 0) return div_q[0];
        if (cls_q.size() > 0) return cls_q[0];
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 128'(out_valid), 128'((div_q.size() + cls_q.size()) > 0));
        chk("out_pkt",   128'(out_pkt),   128'(model_head()));
        chk("div_count", 128'(div_count), 128'(div_q.size()));
        chk("cls_count", 128'(cls_count), 128'(cls_q.size()));
        chk("drop_cnt",  128'(drop_cnt),  128'(drops));
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input noc_packet_t p, input logic rdy, input logic fl,
                        output logic rdy_seen);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_pkt    = p;
        out_ready = rdy;
        flush     = fl;
        #1;
        rdy_seen = in_ready;
        exp_rdy  = model_ready(p, fl);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (fl) begin
            div_q.delete();
            cls_q.delete();
        end else begin
            if (rdy) begin
                if (div_q.size() > 0)      void'(div_q.pop_front());
                else if (cls_q.size() > 0) void'(cls_q.pop_front());
            end
            if (v && exp_rdy) begin
                if (p.msg_type == MSG_DIVERGE)                           div_q.push_back(p);
                else if (p.msg_type == MSG_CLAUSE && p.quality_metric > LBD) begin
                    if (drops < 65535) drops++;
                end
                else                                                     cls_q.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic        r;
        noc_packet_t p;
        in_valid  = 1'b0;
        in_pkt    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_pkt",   128'(out_pkt),   128'(0));
        chk("rst_div_count", 128'(div_count), 128'(0));
        chk("rst_cls_count", 128'(cls_count), 128'(0));
        chk("rst_drop_cnt",  128'(drop_cnt),  128'(0));
        in_pkt = mk(MSG_DIVERGE, 8'd0, 64'd9);
        #1;
        chk("rst_in_ready_div", 128'(in_ready), 128'(1));
        in_pkt = mk(MSG_CLAUSE, 8'd2, 64'd9);
        #1;
        chk("rst_in_ready_cls", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Single divergence packet, one-cycle latency
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'h0000_0000_FFFF_FFFD), 1'b0, 1'b0, r);
        chk("t1_valid",   128'(out_valid),       128'(1));
        chk("t1_payload", 128'(out_pkt.payload), 128'(64'h0000_0000_FFFF_FFFD));
        chk("t1_count1",  128'(div_count),       128'(1));
        step(1'b0, '0, 1'b1, 1'b0, r);
        chk("t1_count0",  128'(div_count),       128'(0));

        // Clause backlog does not block divergence
        for (int k = 1; k <= 4; k++) step(1'b1, mk(MSG_CLAUSE, 8'd2, 64'(k)), 1'b0, 1'b0, r);
        chk("t2_cls_full", 128'(cls_count), 128'(4));
        step(1'b1, mk(MSG_CLAUSE, 8'd2, 64'd5), 1'b0, 1'b0, r);
        chk("t2_5th_refused", 128'(r), 128'(0));
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'hD1), 1'b0, 1'b0, r);
        chk("t2_div_accepted", 128'(r), 128'(1));
        chk("t2_div_first", 128'(out_pkt.payload), 128'(64'hD1));
        step(1'b0, '0, 1'b1, 1'b0, r);
        for (int k = 1; k <= 4; k++) begin
            chk("t2_cls_order", 128'(out_pkt.payload), 128'(k));
            step(1'b0, '0, 1'b1, 1'b0, r);
        end
        chk("t2_drained", 128'(out_valid), 128'(0));

        // LBD filter boundary
        step(1'b1, mk(MSG_CLAUSE, 8'd7, 64'h77), 1'b0, 1'b0, r);
        chk("t3_drop_ready", 128'(r),         128'(1));
        chk("t3_drop_cnt",   128'(drop_cnt),  128'(1));
        chk("t3_no_output",  128'(out_valid), 128'(0));
        step(1'b1, mk(MSG_CLAUSE, 8'd6, 64'h66), 1'b0, 1'b0, r);
        chk("t3_lbd6_kept",  128'(out_pkt.payload), 128'(64'h66));
        step(1'b0, '0, 1'b1, 1'b0, r);

        // Full div queue with simultaneous pop refuses the push
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'hA), 1'b0, 1'b0, r);
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'hB), 1'b0, 1'b0, r);
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'hC), 1'b1, 1'b0, r);
        chk("t4_refused", 128'(r), 128'(0));
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'hC), 1'b0, 1'b0, r);
        chk("t4_accepted", 128'(r), 128'(1));
        chk("t4_head_b", 128'(out_pkt.payload), 128'(64'hB));
        step(1'b0, '0, 1'b1, 1'b0, r);
        chk("t4_head_c", 128'(out_pkt.payload), 128'(64'hC));
        step(1'b0, '0, 1'b1, 1'b0, r);

        // Flush with both queues populated
        for (int k = 0; k < 2; k++) step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'(16 + k)), 1'b0, 1'b0, r);
        for (int k = 0; k < 3; k++) step(1'b1, mk(MSG_STATUS,  8'd0, 64'(32 + k)), 1'b0, 1'b0, r);
        step(1'b1, mk(MSG_CLAUSE, 8'd9, 64'h99), 1'b1, 1'b1, r);
        chk("t5_div_zero",   128'(div_count), 128'(0));
        chk("t5_cls_zero",   128'(cls_count), 128'(0));
        chk("t5_invalid",    128'(out_valid), 128'(0));
        chk("t5_drop_kept",  128'(drop_cnt),  128'(1));

        // Asynchronous reset mid-transfer
        step(1'b1, mk(MSG_DIVERGE, 8'd0, 64'h5), 1'b0, 1'b0, r);
        step(1'b1, mk(MSG_CLAUSE,  8'd1, 64'h6), 1'b0, 1'b0, r);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  128'(out_valid), 128'(0));
        chk("ar_div",    128'(div_count), 128'(0));
        chk("ar_cls",    128'(cls_count), 128'(0));
        chk("ar_drop",   128'(drop_cnt),  128'(0));
        div_q.delete();
        cls_q.delete();
        drops = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized mixed traffic
        for (int i = 0; i < 10000; i++) begin
            int   sel;
            logic v;
            logic rdy;
            logic fl;
            sel = $urandom_range(0, 9);
            if (sel <= 2)      p.msg_type = MSG_DIVERGE;
            else if (sel <= 7) p.msg_type = MSG_CLAUSE;
            else if (sel == 8) p.msg_type = msg_type_e'($urandom_range(3, 4));
            else               p.msg_type = MSG_NOP;
            p.src_id         = 8'($urandom);
            p.quality_metric = 8'($urandom_range(0, 10));
            p.payload        = {$urandom, $urandom};
            v   = ($urandom_range(0, 3) != 0);
            rdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 299) == 0);
            step(v, p, rdy, fl, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
